// File: rtl/mpi_collective_top.sv
// Single-node MPI reduction engine: per-slot accumulators combine rank contributions and emit one packet per completed slot.
// Optional build macro SAT_SUM_EN makes the sum operator saturate instead of wrapping.
module mpi_collective_top #(
    parameter int NUM_SLOTS    = 16,
    parameter int DEFAULT_COMM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dataIn,
    input  logic [2:0]  src,
    input  logic [2:0]  dst,
    input  logic [2:0]  rank,
    input  logic [2:0]  root,
    input  logic [4:0]  op,
    input  logic [3:0]  commsize,
    input  logic [1:0]  algtype,
    input  logic [3:0]  index,
    output logic [63:0] Outpacket,
    output logic        done
);

    logic [1:0]  rst_sync_r;
    logic        rst_n_s;
    logic [31:0] acc_r  [NUM_SLOTS];
    logic [7:0]  mask_r [NUM_SLOTS];
    logic [63:0] pkt_r;
    logic        done_r;

    logic [3:0]  n_s;
    logic        slot_ok_s;
    logic [7:0]  cur_mask_s;
    logic [31:0] cur_acc_s;
    logic [7:0]  new_mask_s;
    logic [31:0] comb_s;
    logic        accept_s;
    logic        complete_s;
    logic [2:0]  dest_s;
    logic [31:0] result_s;

    function automatic logic [31:0] sum_fn(input logic [31:0] a, input logic [31:0] b);
`ifdef SAT_SUM_EN
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        sum_fn = s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
        sum_fn = a + b;
`endif
    endfunction

    function automatic logic [31:0] reduce_fn(input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] sel);
        case (sel)
            5'd0:    reduce_fn = sum_fn(a, b);
            5'd1:    reduce_fn = a * b;
            5'd2:    reduce_fn = (a > b) ? a : b;
            5'd3:    reduce_fn = (a < b) ? a : b;
            5'd4:    reduce_fn = a & b;
            5'd5:    reduce_fn = a | b;
            5'd6:    reduce_fn = a ^ b;
            5'd7:    reduce_fn = ($signed(a) > $signed(b)) ? a : b;
            5'd8:    reduce_fn = ($signed(a) < $signed(b)) ? a : b;
            default: reduce_fn = sum_fn(a, b);
        endcase
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] m);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, m[i]};
        end
        popcount8 = cnt;
    endfunction

    // Reset synchronizer: asserts immediately, releases on the second clock edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // Effective communicator size: zero selects the default, anything above 8 clamps
    always_comb begin
        n_s = commsize;
        if (commsize == 4'd0) begin
            n_s = 4'(DEFAULT_COMM);
        end else if (commsize > 4'd8) begin
            n_s = 4'd8;
        end else begin
            n_s = commsize;
        end
    end

    // Acceptance, combine and completion decode for the addressed slot
    always_comb begin
        slot_ok_s  = ({1'b0, index} < 5'(NUM_SLOTS));
        cur_mask_s = 8'd0;
        cur_acc_s  = 32'd0;
        if (slot_ok_s) begin
            cur_mask_s = mask_r[index];
            cur_acc_s  = acc_r[index];
        end else begin
            cur_mask_s = 8'd0;
            cur_acc_s  = 32'd0;
        end
        accept_s   = (dst == rank) && ({1'b0, src} < n_s) && slot_ok_s && !cur_mask_s[src];
        new_mask_s = cur_mask_s | (8'd1 << src);
        if (cur_mask_s == 8'd0) begin
            comb_s = dataIn;
        end else begin
            comb_s = reduce_fn(cur_acc_s, dataIn, op);
        end
        // popcount >= N also completes, covering a communicator shrunk mid-slot
        complete_s = accept_s && (popcount8(new_mask_s) >= n_s);
    end

    // Packet destination and payload by algorithm
    always_comb begin
        dest_s   = root;
        result_s = comb_s;
        case (algtype)
            2'd1: begin
                dest_s   = 3'b111;
                result_s = comb_s;
            end
            2'd2: begin
                dest_s   = 3'b111;
                result_s = 32'd0;
            end
            default: begin
                dest_s   = root;
                result_s = comb_s;
            end
        endcase
    end

    // Slot state update and registered result packet
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                acc_r[i]  <= 32'd0;
                mask_r[i] <= 8'd0;
            end
            pkt_r  <= 64'd0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                if (complete_s) begin
                    mask_r[index] <= 8'd0;
                    acc_r[index]  <= 32'd0;
                    pkt_r         <= {rank, dest_s, op, index, algtype, 15'd0, result_s};
                    done_r        <= 1'b1;
                end else begin
                    mask_r[index] <= new_mask_s;
                    acc_r[index]  <= comb_s;
                end
            end
        end
    end

    assign Outpacket = pkt_r;
    assign done      = done_r;

endmodule

// File: tb/tb_mpi_collective_top.sv
// Scoreboard bench for mpi_collective_top: expected packets are queued when the completing
// contributions are driven and compared whenever done pulses.
module tb_mpi_collective_top;

    logic        clk;
    logic        rst;
    logic [31:0] dataIn;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic [2:0]  rank;
    logic [2:0]  root;
    logic [4:0]  op;
    logic [3:0]  commsize;
    logic [1:0]  algtype;
    logic [3:0]  index;
    logic [63:0] Outpacket;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    mpi_collective_top #(.NUM_SLOTS(16), .DEFAULT_COMM(4)) dut (
        .clk(clk), .rst(rst), .dataIn(dataIn), .src(src), .dst(dst), .rank(rank),
        .root(root), .op(op), .commsize(commsize), .algtype(algtype), .index(index),
        .Outpacket(Outpacket), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_pkt(input logic [2:0] rk, input logic [1:0] alg,
                                           input logic [2:0] rt, input logic [4:0] o,
                                           input logic [3:0] ix, input logic [31:0] res);
        logic [2:0]  d;
        logic [31:0] r;
        d = (alg == 2'd1 || alg == 2'd2) ? 3'b111 : rt;
        r = (alg == 2'd2) ? 32'd0 : res;
        return {rk, d, o, ix, alg, 15'd0, r};
    endfunction

    task automatic send(input logic [2:0] s, input logic [3:0] ix, input logic [31:0] d);
        src = s; index = ix; dataIn = d; dst = rank;
        @(posedge clk); #1;
        dst = ~rank;
    endtask

    task automatic send_bad_dst(input logic [2:0] s, input logic [3:0] ix, input logic [31:0] d);
        src = s; index = ix; dataIn = d; dst = ~rank;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        chk("reset_pkt", Outpacket, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every done pulse must match the oldest queued packet
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst && done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", {63'd0, done}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("packet", Outpacket, e);
                end
            end
        end
    end

    initial begin
        logic [2:0]  seq_src [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        logic [3:0]  seq_idx [9] = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        logic [31:0] seq_dat [9] = '{32'd6, 32'd5, 32'd4, 32'd2, 32'd3, 32'd1, 32'd1, 32'd1, 32'd1};
        logic [4:0]  ops [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd12};
`ifdef SAT_SUM_EN
        logic [31:0] res [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFF6, 32'hFFFF_FFFE, 32'd5, 32'd4,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] sat_exp = 32'hFFFF_FFFF;
`else
        logic [31:0] res [10] = '{32'd3, 32'hFFFF_FFF6, 32'hFFFF_FFFE, 32'd5, 32'd4,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd5, 32'hFFFF_FFFE, 32'd3};
        logic [31:0] sat_exp = 32'h0000_0010;
`endif

        rst = 1'b0; dataIn = 32'd0; src = 3'd0; rank = 3'd0; dst = 3'd7; root = 3'd0;
        op = 5'd0; commsize = 4'd0; algtype = 2'd0; index = 4'd0;
        #100;
        chk("reset_pkt", Outpacket, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_pkt", Outpacket, 64'd0);
        chk("idle_done", {63'd0, done}, 64'd0);

        // Interleaved sum over the default communicator, duplicates discarded
        exp_q.push_back({3'd0, 3'd0, 5'd0, 4'd0, 2'd0, 15'd0, 32'd5});
        for (int i = 0; i < 9; i++) send(seq_src[i], seq_idx[i], seq_dat[i]);
        drain("interleave_drain");
        exp_q.push_back(mk_pkt(3'd0, 2'd0, 3'd0, 5'd0, 4'd1, 32'd15));
        send(3'd3, 4'd1, 32'd0);
        drain("slot1_drain");

        // Unsigned max as allreduce over three ranks
        op = 5'd2; algtype = 2'd1; commsize = 4'd3;
        exp_q.push_back(mk_pkt(3'd0, 2'd1, 3'd0, 5'd2, 4'd5, 32'hFFFF_0000));
        send(3'd0, 4'd5, 32'd7);
        send(3'd1, 4'd5, 32'hFFFF_0000);
        send(3'd2, 4'd5, 32'd9);
        drain("max_drain");

        // Filtering: wrong destination and out-of-communicator source are ignored
        rank = 3'd2; root = 3'd1; op = 5'd5; algtype = 2'd0; commsize = 4'd4;
        send_bad_dst(3'd0, 4'd7, 32'h100);
        send(3'd5, 4'd7, 32'h200);
        exp_q.push_back(mk_pkt(3'd2, 2'd0, 3'd1, 5'd5, 4'd7, 32'hF));
        send(3'd0, 4'd7, 32'd1);
        send(3'd1, 4'd7, 32'd2);
        send(3'd2, 4'd7, 32'd4);
        send(3'd3, 4'd7, 32'd8);
        drain("filter_drain");

        // Reset mid-slot discards the partial contributions
        rank = 3'd0; root = 3'd0; op = 5'd0; commsize = 4'd4;
        send(3'd0, 4'd3, 32'd10);
        send(3'd1, 4'd3, 32'd20);
        send(3'd2, 4'd3, 32'd30);
        do_reset(3);
        send(3'd3, 4'd3, 32'd40);
        drain("midreset_nodone");
        exp_q.push_back(mk_pkt(3'd0, 2'd0, 3'd0, 5'd0, 4'd3, 32'd46));
        send(3'd0, 4'd3, 32'd1);
        send(3'd1, 4'd3, 32'd2);
        send(3'd2, 4'd3, 32'd3);
        drain("midreset_drain");

        // Communicator shrinks mid-slot: popcount above N completes
        commsize = 4'd4;
        send(3'd2, 4'd9, 32'd1);
        send(3'd3, 4'd9, 32'd2);
        commsize = 4'd2;
        exp_q.push_back(mk_pkt(3'd0, 2'd0, 3'd0, 5'd0, 4'd9, 32'd7));
        send(3'd0, 4'd9, 32'd4);
        drain("shrink_drain");

        // Every operator across all algorithm types, two ranks
        rank = 3'd1; root = 3'd3; commsize = 4'd2;
        for (int k = 0; k < 10; k++) begin
            op = ops[k];
            algtype = 2'(k % 4);
            exp_q.push_back(mk_pkt(3'd1, 2'(k % 4), 3'd3, ops[k], 4'd12, res[k]));
            send(3'd0, 4'd12, 32'hFFFF_FFFE);
            send(3'd1, 4'd12, 32'd5);
            drain("op_drain");
        end

        // Sum overflow: saturates or wraps depending on build
        op = 5'd0; algtype = 2'd0;
        exp_q.push_back(mk_pkt(3'd1, 2'd0, 3'd3, 5'd0, 4'd11, sat_exp));
        send(3'd0, 4'd11, 32'hFFFF_FFF0);
        send(3'd1, 4'd11, 32'h20);
        drain("sat_drain");
        chk("hold_pkt", Outpacket, mk_pkt(3'd1, 2'd0, 3'd3, 5'd0, 4'd11, sat_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
